// File: rtl/aes_sbox_scheduler_if.sv
// Request/result handshakes between the S-box scheduler and its two requesters:
// the round datapath (128-bit block) and the key expansion (32-bit SubWord).
interface aes_sbox_scheduler_if;
  logic         blk_in_valid;
  logic         blk_in_ready;
  logic         blk_in_encrypt;
  logic [127:0] blk_in_data;
  logic         blk_out_valid;
  logic         blk_out_ready;
  logic [127:0] blk_out_data;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [31:0]  key_in_word;
  logic         key_out_valid;
  logic         key_out_ready;
  logic [31:0]  key_out_word;

  modport slave (
    input  blk_in_valid, blk_in_encrypt, blk_in_data, blk_out_ready,
    input  key_in_valid, key_in_word, key_out_ready,
    output blk_in_ready, blk_out_valid, blk_out_data,
    output key_in_ready, key_out_valid, key_out_word
  );

  modport master (
    output blk_in_valid, blk_in_encrypt, blk_in_data, blk_out_ready,
    output key_in_valid, key_in_word, key_out_ready,
    input  blk_in_ready, blk_out_valid, blk_out_data,
    input  key_in_ready, key_out_valid, key_out_word
  );
endinterface

// File: rtl/aes_sbox_scheduler.sv
// Shares SBOX_LANES forward/inverse S-box lane pairs between a 128-bit block requester and a
// 32-bit SubWord requester, processing SBOX_LANES bytes per beat with result buffering.
module aes_sbox_scheduler #(
  parameter int unsigned SBOX_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_sbox_scheduler_if.slave    bus
);

  localparam int Lanes     = int'(SBOX_LANES);
  localparam int BlkBeats  = 16 / Lanes;
  localparam int KeyLanes  = (Lanes < 4) ? Lanes : 4;
  localparam int KeyBeats  = 4 / KeyLanes;
  localparam int BeatW     = (BlkBeats > 1) ? $clog2(BlkBeats) : 1;

  typedef enum logic [1:0] {StIdle, StBlkBusy, StKeyBusy} state_e;

  state_e             state_q, state_d;
  logic               prio_key_q, prio_key_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [127:0]       work_q, work_d;
  logic               enc_q, enc_d;
  logic               blk_vld_q, blk_vld_d;
  logic [127:0]       blk_dat_q, blk_dat_d;
  logic               key_vld_q, key_vld_d;
  logic [31:0]        key_dat_q, key_dat_d;
  logic [7:0]         lane_in  [Lanes];
  logic [7:0]         lane_out [Lanes];
  logic               blk_elig, key_elig, grant_blk, grant_key;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 7; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  // A pending result blocks only its own path; ready is forced low while in reset.
  always_comb begin
    blk_elig  = bus.blk_in_valid & ~blk_vld_q;
    key_elig  = bus.key_in_valid & ~key_vld_q;
    grant_blk = 1'b0;
    grant_key = 1'b0;
    if (rst_n && state_q == StIdle) begin
      if (blk_elig && key_elig) begin
        grant_key = prio_key_q;
        grant_blk = ~prio_key_q;
      end else begin
        grant_blk = blk_elig;
        grant_key = key_elig;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < Lanes; l++) begin
      lane_in[l] = 8'h00;
      if (state_q == StKeyBusy) begin
        if (l < KeyLanes) lane_in[l] = work_q[(int'(beat_q) * KeyLanes + l) * 8 +: 8];
      end else begin
        lane_in[l] = work_q[(int'(beat_q) * Lanes + l) * 8 +: 8];
      end
      lane_out[l] = (state_q == StBlkBusy && !enc_q) ? sbox_inv(lane_in[l])
                                                     : sbox_fwd(lane_in[l]);
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_key_d = prio_key_q;
    beat_d     = beat_q;
    work_d     = work_q;
    enc_d      = enc_q;
    blk_vld_d  = blk_vld_q;
    blk_dat_d  = blk_dat_q;
    key_vld_d  = key_vld_q;
    key_dat_d  = key_dat_q;

    if (blk_vld_q && bus.blk_out_ready) blk_vld_d = 1'b0;
    if (key_vld_q && bus.key_out_ready) key_vld_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (blk_elig && key_elig) prio_key_d = ~prio_key_q;
        if (grant_blk) begin
          work_d  = bus.blk_in_data;
          enc_d   = bus.blk_in_encrypt;
          beat_d  = '0;
          state_d = StBlkBusy;
        end else if (grant_key) begin
          work_d  = {96'h0, bus.key_in_word};
          beat_d  = '0;
          state_d = StKeyBusy;
        end
      end
      StBlkBusy: begin
        for (int l = 0; l < Lanes; l++) begin
          work_d[(int'(beat_q) * Lanes + l) * 8 +: 8] = lane_out[l];
        end
        if (beat_q == BeatW'(BlkBeats - 1)) begin
          beat_d    = '0;
          blk_vld_d = 1'b1;
          blk_dat_d = work_d;
          state_d   = StIdle;
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      StKeyBusy: begin
        for (int l = 0; l < KeyLanes; l++) begin
          work_d[(int'(beat_q) * KeyLanes + l) * 8 +: 8] = lane_out[l];
        end
        if (beat_q == BeatW'(KeyBeats - 1)) begin
          beat_d    = '0;
          key_vld_d = 1'b1;
          key_dat_d = work_d[31:0];
          state_d   = StIdle;
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prio_key_q <= 1'b1;
      beat_q     <= '0;
      work_q     <= '0;
      enc_q      <= 1'b0;
      blk_vld_q  <= 1'b0;
      blk_dat_q  <= '0;
      key_vld_q  <= 1'b0;
      key_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      prio_key_q <= prio_key_d;
      beat_q     <= beat_d;
      work_q     <= work_d;
      enc_q      <= enc_d;
      blk_vld_q  <= blk_vld_d;
      blk_dat_q  <= blk_dat_d;
      key_vld_q  <= key_vld_d;
      key_dat_q  <= key_dat_d;
    end
  end

  assign bus.blk_in_ready  = grant_blk;
  assign bus.key_in_ready  = grant_key;
  assign bus.blk_out_valid = blk_vld_q;
  assign bus.blk_out_data  = blk_dat_q;
  assign bus.key_out_valid = key_vld_q;
  assign bus.key_out_word  = key_dat_q;

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Directed plus randomized checks of the S-box scheduler against a table-driven model
// (S-box built from the generator-3 / affine walk, inverse by table inversion).
module tb_aes_sbox_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_sbox_scheduler_if bus ();
  aes_sbox_scheduler_if bus1 ();

  aes_sbox_scheduler #(.SBOX_LANES(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  aes_sbox_scheduler #(.SBOX_LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  localparam logic [127:0] V0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic [7:0] fwd [256];
  logic [7:0] inv [256];
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      fwd[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);
  endtask

  function automatic logic [127:0] m_blk(input logic [127:0] d, input logic enc);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = enc ? fwd[d[8*i +: 8]] : inv[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = fwd[w[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_req(input logic [31:0] w, input string tag);
    int n;
    bus.key_in_valid = 1'b1;
    bus.key_in_word  = w;
    #1;
    n = 0;
    while (!bus.key_in_ready && n < 50) begin tick(); n++; end
    check({tag, "_rdy"}, 128'(bus.key_in_ready), 128'd1);
    tick();
    bus.key_in_valid = 1'b0;
    bus.key_in_word  = $urandom;
    n = 0;
    while (!bus.key_out_valid && n < 50) begin tick(); n++; end
    check({tag, "_lat"}, 128'(n), 128'd1);
    check({tag, "_word"}, 128'(bus.key_out_word), 128'(m_word(w)));
    bus.key_out_ready = 1'b1;
    tick();
    bus.key_out_ready = 1'b0;
    check({tag, "_clr"}, 128'(bus.key_out_valid), 128'd0);
  endtask

  task automatic blk_req(input logic [127:0] d, input logic enc, input string tag);
    int n;
    bus.blk_in_valid   = 1'b1;
    bus.blk_in_data    = d;
    bus.blk_in_encrypt = enc;
    #1;
    n = 0;
    while (!bus.blk_in_ready && n < 50) begin tick(); n++; end
    check({tag, "_rdy"}, 128'(bus.blk_in_ready), 128'd1);
    tick();
    bus.blk_in_valid   = 1'b0;
    bus.blk_in_data    = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_in_encrypt = ~enc;
    n = 0;
    while (!bus.blk_out_valid && n < 50) begin tick(); n++; end
    check({tag, "_lat"}, 128'(n), 128'd4);
    check({tag, "_data"}, bus.blk_out_data, m_blk(d, enc));
    bus.blk_out_ready = 1'b1;
    tick();
    bus.blk_out_ready = 1'b0;
    check({tag, "_clr"}, 128'(bus.blk_out_valid), 128'd0);
  endtask

  initial begin
    int n;
    logic [31:0] kw;
    logic [127:0] d1, d2, exp_hold;
    build_tables();
    bus.blk_in_valid = 0; bus.blk_in_encrypt = 0; bus.blk_in_data = '0; bus.blk_out_ready = 0;
    bus.key_in_valid = 0; bus.key_in_word = '0; bus.key_out_ready = 0;
    bus1.blk_in_valid = 0; bus1.blk_in_encrypt = 0; bus1.blk_in_data = '0;
    bus1.blk_out_ready = 0; bus1.key_in_valid = 0; bus1.key_in_word = '0;
    bus1.key_out_ready = 0;

    // Reset with both requests already pending; readies must stay low.
    bus.blk_in_valid = 1; bus.blk_in_data = V0; bus.blk_in_encrypt = 1;
    bus.key_in_valid = 1; bus.key_in_word = 32'h09cf4f3c;
    tick(); tick();
    check("rst_blk_vld", 128'(bus.blk_out_valid), 0);
    check("rst_key_vld", 128'(bus.key_out_valid), 0);
    check("rst_blk_data", bus.blk_out_data, 0);
    check("rst_key_word", 128'(bus.key_out_word), 0);
    check("rst_blk_rdy", 128'(bus.blk_in_ready), 0);
    check("rst_key_rdy", 128'(bus.key_in_ready), 0);

    // First contention: key wins.
    rst_n = 1;
    #1;
    check("c1_key_rdy", 128'(bus.key_in_ready), 1);
    check("c1_blk_rdy", 128'(bus.blk_in_ready), 0);
    tick();
    bus.key_in_valid = 0;
    check("c1_blk_wait", 128'(bus.blk_in_ready), 0);
    tick();
    check("c1_key_vld", 128'(bus.key_out_valid), 1);
    check("c1_key_const", 128'(bus.key_out_word), 128'h018a84eb);
    check("c1_key_model", 128'(bus.key_out_word), 128'(m_word(32'h09cf4f3c)));
    check("c1_blk_next", 128'(bus.blk_in_ready), 1);
    tick();
    bus.blk_in_valid = 0;
    bus.blk_in_data = '1;
    n = 0;
    while (!bus.blk_out_valid && n < 50) begin tick(); n++; end
    check("c1_blk_lat", 128'(n), 4);
    check("c1_blk_const", bus.blk_out_data, V1);
    check("c1_blk_model", bus.blk_out_data, m_blk(V0, 1'b1));
    bus.blk_out_ready = 1; bus.key_out_ready = 1;
    tick();
    bus.blk_out_ready = 0; bus.key_out_ready = 0;
    check("c1_consumed", 128'({bus.blk_out_valid, bus.key_out_valid}), 0);

    // Second contention: block wins; inverse round trip.
    kw = $urandom;
    bus.blk_in_valid = 1; bus.blk_in_data = V1; bus.blk_in_encrypt = 0;
    bus.key_in_valid = 1; bus.key_in_word = kw;
    #1;
    check("c2_blk_rdy", 128'(bus.blk_in_ready), 1);
    check("c2_key_rdy", 128'(bus.key_in_ready), 0);
    tick();
    bus.blk_in_valid = 0;
    n = 0;
    while (!bus.blk_out_valid && n < 50) begin tick(); n++; end
    check("c2_blk_lat", 128'(n), 4);
    check("c2_roundtrip", bus.blk_out_data, V0);
    key_req(kw, "c2_key");
    check("c2_blk_held", bus.blk_out_data, V0);
    bus.blk_out_ready = 1;
    tick();
    bus.blk_out_ready = 0;

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1)
        blk_req({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), "rnd_blk");
      else
        key_req($urandom, "rnd_key");
    end

    // Backpressure: result held while key requests are still served.
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_in_valid = 1; bus.blk_in_data = d1; bus.blk_in_encrypt = 1;
    #1;
    check("bp_rdy1", 128'(bus.blk_in_ready), 1);
    tick();
    bus.blk_in_data = d2;
    exp_hold = m_blk(d1, 1'b1);
    n = 0;
    while (!bus.blk_out_valid && n < 50) begin tick(); n++; end
    check("bp_lat", 128'(n), 4);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", bus.blk_out_data, exp_hold);
      check("bp_blk_rdy", 128'({bus.blk_in_ready, bus.blk_out_valid}), 128'b01);
      tick();
    end
    key_req($urandom, "bp_key_a");
    key_req($urandom, "bp_key_b");
    check("bp_hold_after_key", bus.blk_out_data, exp_hold);
    bus.blk_out_ready = 1;
    tick();
    bus.blk_out_ready = 0;
    check("bp_clr", 128'(bus.blk_out_valid), 0);
    check("bp_rdy2", 128'(bus.blk_in_ready), 1);
    tick();
    bus.blk_in_valid = 0;
    n = 0;
    while (!bus.blk_out_valid && n < 50) begin tick(); n++; end
    check("bp_lat2", 128'(n), 4);
    check("bp_data2", bus.blk_out_data, m_blk(d2, 1'b1));
    bus.blk_out_ready = 1;
    tick();
    bus.blk_out_ready = 0;

    // Reset mid-block with a held key result; pointer must return to KEY.
    d1 = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_in_valid = 1; bus.blk_in_data = d1; bus.blk_in_encrypt = 1;
    bus.key_in_valid = 1; bus.key_in_word = $urandom;
    #1;
    check("r_cont_key", 128'(bus.key_in_ready), 1);
    tick();
    bus.key_in_valid = 0;
    tick();
    check("r_pend", 128'(bus.key_out_valid), 1);
    check("r_blk_rdy", 128'(bus.blk_in_ready), 1);
    tick();
    bus.blk_in_valid = 0;
    tick(); tick();
    rst_n = 0;
    kw = $urandom;
    d2 = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_in_valid = 1; bus.blk_in_data = d2;
    bus.key_in_valid = 1; bus.key_in_word = kw;
    tick();
    check("r_blk_vld", 128'(bus.blk_out_valid), 0);
    check("r_key_vld", 128'(bus.key_out_valid), 0);
    check("r_blk_data", bus.blk_out_data, 0);
    check("r_key_word", 128'(bus.key_out_word), 0);
    check("r_rdys", 128'({bus.blk_in_ready, bus.key_in_ready}), 0);
    rst_n = 1;
    #1;
    check("r_ptr_key", 128'({bus.key_in_ready, bus.blk_in_ready}), 128'b10);
    bus.blk_in_valid = 0;
    key_req(kw, "r_key");
    blk_req(d2, 1'b1, "r_blk");

    // Single-lane instance: SubWord takes 4 beats, a block 16.
    bus1.key_in_valid = 1; bus1.key_in_word = 32'h09cf4f3c;
    #1;
    check("l1_key_rdy", 128'(bus1.key_in_ready), 1);
    tick();
    bus1.key_in_valid = 0;
    n = 0;
    while (!bus1.key_out_valid && n < 50) begin tick(); n++; end
    check("l1_key_lat", 128'(n), 4);
    check("l1_key_word", 128'(bus1.key_out_word), 128'h018a84eb);
    bus1.key_out_ready = 1;
    tick();
    bus1.key_out_ready = 0;
    bus1.blk_in_valid = 1; bus1.blk_in_data = V1; bus1.blk_in_encrypt = 0;
    #1;
    check("l1_blk_rdy", 128'(bus1.blk_in_ready), 1);
    tick();
    bus1.blk_in_valid = 0;
    n = 0;
    while (!bus1.blk_out_valid && n < 50) begin tick(); n++; end
    check("l1_blk_lat", 128'(n), 16);
    check("l1_blk_data", bus1.blk_out_data, V0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
